i_cache_dm: RTL

- Parametrised direct-mapped instruction cache: next generation of the single-word instruction cache, with multi-word lines, configurable depth, a valid/ready CPU request channel, flush, and error reporting.
- Sits between the fetch stage and the instruction-memory AXI4-Lite read port.
- Refills a whole line on a miss as WORDS_PER_LINE sequential single-beat AXI4-Lite reads.

---
 rtl/i_cache_dm.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/i_cache_dm.sv
// Direct-mapped instruction cache with multi-word lines.
// Sits between the fetch stage and an AXI4-Lite instruction-memory read port.
// A miss refills the whole line, word 0 upward, as single-beat reads.
// Optional feature: define ICACHE_PERF_EN to add saturating hit/miss counters
// (perf_hits / perf_misses).
module i_cache_dm #(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  input  logic              flush,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [2:0]        axi_arprot,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  input  logic [31:0]       axi_rdata,
  input  logic [1:0]        axi_rresp
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int WO_W  = $clog2(WORDS_PER_LINE);
  localparam int CNT_W = (WO_W > 0) ? WO_W : 1;
  localparam int TAG_W = ADDR_W - 2 - WO_W - IDX_W;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Storage: valid bits are control and reset; tags and words are not.
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag_arr [LINES];
  logic [31:0]      r_data    [LINES][WORDS_PER_LINE];

  // Request latched at acceptance, used for the refill and its response.
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_off;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_flush_pend;

  // Hit response register (one cycle behind acceptance).
  logic             r_resp_vld_p1;
  logic [31:0]      r_resp_data_p1;

  logic [IDX_W-1:0] w_req_idx;
  logic [CNT_W-1:0] w_req_off;
  logic [TAG_W-1:0] w_req_tag;
  logic             w_hit;
  logic             w_accept;
  logic             w_beat;
  logic             w_last;

  assign w_req_idx = IDX_W'(req_addr >> (2 + WO_W));
  assign w_req_off = CNT_W'(req_addr >> 2) & LAST_WORD;
  assign w_req_tag = TAG_W'(req_addr >> (2 + WO_W + IDX_W));
  assign w_hit     = r_valid[w_req_idx] && (r_tag_arr[w_req_idx] == w_req_tag);
  assign w_accept  = req_valid && req_ready;
  assign w_beat    = (r_state == S_R) && axi_rvalid;
  assign w_last    = (r_cnt == LAST_WORD);

  assign req_ready   = (r_state == S_IDLE) && !flush;
  assign axi_arvalid = (r_state == S_AR);
  assign axi_rready  = (r_state == S_R);
  assign axi_arprot  = 3'b101;
  assign axi_araddr  = (r_state == S_AR)
                     ? ((ADDR_W'({r_tag, r_idx}) << (2 + WO_W)) | (ADDR_W'(r_cnt) << 2))
                     : '0;

  // Refill responses come straight from the array during RESP; hits come
  // from the registered lookup.
  assign resp_valid = r_resp_vld_p1 || (r_state == S_RESP);
  assign resp_data  = (r_state == S_RESP) ? r_data[r_idx][r_off] : r_resp_data_p1;
  assign resp_err   = (r_state == S_RESP) && r_err;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic for the refill sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && !w_hit) w_state_nxt = S_AR;
      S_AR:   if (axi_arready) w_state_nxt = S_R;
      S_R:    if (axi_rvalid) w_state_nxt = w_last ? S_RESP : S_AR;
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: valid bits, word counter, error and pending-flush flags, hit response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid        <= '0;
      r_cnt          <= '0;
      r_err          <= 1'b0;
      r_flush_pend   <= 1'b0;
      r_resp_vld_p1  <= 1'b0;
      r_resp_data_p1 <= '0;
    end else begin
      // p0 -> p1: registered hit lookup
      r_resp_vld_p1 <= w_accept && w_hit;
      if (w_accept && w_hit) r_resp_data_p1 <= r_data[w_req_idx][w_req_off];

      if ((r_state == S_AR || r_state == S_R) && flush) r_flush_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (flush) r_valid <= '0;
          if (w_accept && !w_hit) r_cnt <= '0;
        end
        S_R: begin
          if (w_beat) begin
            r_err <= r_err | (axi_rresp != 2'b00);
            if (!w_last) r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          // A flush seen during the refill wins over marking the line valid.
          if (r_flush_pend || flush) r_valid <= '0;
          else if (!r_err)           r_valid[r_idx] <= 1'b1;
          r_err        <= 1'b0;
          r_flush_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath storage: request latch, refill words and tag write.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag <= w_req_tag;
      r_idx <= w_req_idx;
      r_off <= w_req_off;
    end
    if (w_beat) r_data[r_idx][r_cnt] <= axi_rdata;
    if (r_state == S_RESP && !r_err) r_tag_arr[r_idx] <= r_tag;
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_perf_hits;
  logic [31:0] r_perf_misses;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating hit/miss counters; flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_hits   <= '0;
      r_perf_misses <= '0;
    end else if (w_accept) begin
      if (w_hit) r_perf_hits   <= sat_inc(r_perf_hits);
      else       r_perf_misses <= sat_inc(r_perf_misses);
    end
  end

  assign perf_hits   = r_perf_hits;
  assign perf_misses = r_perf_misses;
`endif

endmodule
